// File: rtl/kmeans_pkg.sv
// Shared types and defaults for the k-means front end staging blocks.
// Holds the burst_replay_buffer FSM state type and its default geometry.
package kmeans_pkg;

    typedef enum logic [1:0] {
        BRB_IDLE    = 2'd0,
        BRB_CAPTURE = 2'd1,
        BRB_DRAIN   = 2'd2
    } brb_state_t;

    localparam int BRB_DATA_W = 16;
    localparam int BRB_DEPTH  = 4096;

endpackage

// File: rtl/brb_sram_sp.sv
// Single-port synchronous SRAM, write-priority, 1-cycle registered read.
// Define BRB_FOUNDRY_SRAM to bind the 4096x16 geometry to the foundry macro.
module brb_sram_sp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

`ifdef BRB_FOUNDRY_SRAM
    localparam bit USE_MACRO = (DATA_W == 16) && (DEPTH == 4096);
`else
    localparam bit USE_MACRO = 1'b0;
`endif

    if (USE_MACRO) begin : g_macro
`ifdef BRB_FOUNDRY_SRAM
        sp_sram_4096x16 u_macro (
            .CLK (clk),
            .CEN (1'b0),
            .WEN (~we),
            .A   (addr),
            .D   (wdata),
            .Q   (rdata)
        );
`endif
    end else begin : g_array
        logic [DATA_W-1:0] mem_reg [DEPTH];
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (we) begin
                mem_reg[addr] <= wdata;
            end
            rdata_reg <= mem_reg[addr];
        end

        assign rdata = rdata_reg;
    end

endmodule

// File: rtl/burst_replay_buffer.sv
// Captures one contiguous burst into single-port SRAM and replays it with valid/ready.
// Define BURST_REPLAY_REVERSE_EN to honour mode_rev (last-in first-out replay).
module burst_replay_buffer
    import kmeans_pkg::*;
#(
    parameter int DATA_W = BRB_DATA_W,
    parameter int DEPTH  = BRB_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode_rev,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [ADDR_W:0]   burst_len,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    brb_state_t             state_reg;
    logic [ADDR_W:0]        burst_len_reg;
    logic [ADDR_W:0]        issue_cnt_reg;
    logic                   overflow_reg;
    logic                   rd_inflight_reg;
    logic                   rd_last_reg;
    logic [1:0]             fifo_cnt_reg;
    logic                   fifo_wr_ptr_reg;
    logic                   fifo_rd_ptr_reg;
    logic [1:0][DATA_W-1:0] fifo_data_reg;
    logic [1:0]             fifo_last_reg;

    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   pop;
    logic                   rd_issue;
    logic                   rd_is_last;
    logic [2:0]             occ;

`ifdef BURST_REPLAY_REVERSE_EN
    logic                   rev_reg;
    logic [ADDR_W-1:0]      rev_addr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rev_reg      <= 1'b0;
            rev_addr_reg <= '0;
        end else begin
            if (state_reg == BRB_IDLE && in_valid) begin
                rev_reg <= mode_rev;
            end
            if (state_reg == BRB_CAPTURE && !in_valid) begin
                rev_addr_reg <= ADDR_W'(burst_len_reg - ONE_L);
            end else if (rd_issue) begin
                rev_addr_reg <= rev_addr_reg - ADDR_W'(1);
            end
        end
    end

    assign rd_addr = rev_reg ? rev_addr_reg : issue_cnt_reg[ADDR_W-1:0];
`else
    logic unused_mode_rev;
    assign unused_mode_rev = mode_rev;
    assign rd_addr         = issue_cnt_reg[ADDR_W-1:0];
`endif

    // Reads are issued only while skid FIFO plus in-flight read leaves room after this cycle's pop.
    always_comb begin
        pop        = (fifo_cnt_reg != 2'd0) && out_ready;
        occ        = {1'b0, fifo_cnt_reg} + {2'b00, rd_inflight_reg};
        rd_is_last = (issue_cnt_reg == (burst_len_reg - ONE_L));
        rd_issue   = (state_reg == BRB_DRAIN) && (issue_cnt_reg < burst_len_reg) &&
                     ((occ < 3'd2) || ((occ == 3'd2) && pop));
        mem_we     = in_valid && ((state_reg == BRB_IDLE) ||
                     ((state_reg == BRB_CAPTURE) && (burst_len_reg < DEPTH_L)));
        mem_addr   = rd_addr;
        if (mem_we) begin
            mem_addr = (state_reg == BRB_IDLE) ? '0 : burst_len_reg[ADDR_W-1:0];
        end
    end

    brb_sram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (in_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= BRB_IDLE;
            burst_len_reg   <= '0;
            issue_cnt_reg   <= '0;
            overflow_reg    <= 1'b0;
            rd_inflight_reg <= 1'b0;
            rd_last_reg     <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_data_reg   <= '0;
            fifo_last_reg   <= '0;
        end else begin
            case (state_reg)
                BRB_IDLE: begin
                    if (in_valid) begin
                        burst_len_reg <= ONE_L;
                        overflow_reg  <= 1'b0;
                        state_reg     <= BRB_CAPTURE;
                    end
                end
                BRB_CAPTURE: begin
                    if (in_valid) begin
                        if (burst_len_reg < DEPTH_L) begin
                            burst_len_reg <= burst_len_reg + ONE_L;
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end else begin
                        issue_cnt_reg <= '0;
                        state_reg     <= BRB_DRAIN;
                    end
                end
                BRB_DRAIN: begin
                    if (pop && out_last) begin
                        state_reg <= BRB_IDLE;
                    end
                end
                default: state_reg <= BRB_IDLE;
            endcase

            if (rd_issue) begin
                issue_cnt_reg <= issue_cnt_reg + ONE_L;
            end
            rd_inflight_reg <= rd_issue;
            rd_last_reg     <= rd_issue && rd_is_last;

            if (rd_inflight_reg) begin
                fifo_data_reg[fifo_wr_ptr_reg] <= mem_rdata;
                fifo_last_reg[fifo_wr_ptr_reg] <= rd_last_reg;
                fifo_wr_ptr_reg                <= ~fifo_wr_ptr_reg;
            end
            if (pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            fifo_cnt_reg <= fifo_cnt_reg + 2'(rd_inflight_reg) - 2'(pop);
        end
    end

    assign in_ready  = (state_reg != BRB_DRAIN);
    assign out_valid = (fifo_cnt_reg != 2'd0);
    assign out_data  = fifo_data_reg[fifo_rd_ptr_reg];
    assign out_last  = fifo_last_reg[fifo_rd_ptr_reg];
    assign burst_len = burst_len_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_burst_replay_buffer.sv
// Directed bench for burst_replay_buffer (DEPTH=8): table of bursts plus a mid-replay reset.
// Reverse-order expectations follow BURST_REPLAY_REVERSE_EN.
`timescale 1ns/1ps
module tb_burst_replay_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mode_rev;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic [AW:0]   burst_len;
    logic          overflow;

    always #5 clk = ~clk;

    burst_replay_buffer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode_rev  (mode_rev),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .burst_len (burst_len),
        .overflow  (overflow)
    );

    typedef struct packed {
        int                    n_in;
        logic [11:0][DW-1:0]   din;
        logic                  rev;
        logic                  toggle;
        int                    n_out;
        logic [11:0][DW-1:0]   dout;
        int                    exp_len;
        logic                  exp_ovf;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        vec_t         t;
        int           idx;
        int           cyc;
        logic         r;
        logic         stalled;
        logic [DW-1:0] held_data;
        logic         held_last;
        t = vecs[v];
        mode_rev  = t.rev;
        out_ready = 1'b0;
        for (int i = 0; i < t.n_in; i++) begin
            in_valid = 1'b1;
            in_data  = t.din[i];
            @(posedge clk); #1;
            if (i == 0) begin
                check("start_len", 32'(burst_len), 32'd1);
                check("start_ovf", 32'(overflow), 32'd0);
                check("capture_in_ready", 32'(in_ready), 32'd1);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk); #1;
        check("drain_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("latency_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_first", 32'(out_valid), 32'd1);

        idx       = 0;
        cyc       = 0;
        stalled   = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        while (idx < t.n_out && cyc < 200) begin
            r = t.toggle ? (cyc % 2 == 1) : 1'b1;
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held_data));
                check("stall_last", 32'(out_last), 32'(held_last));
            end
            out_ready = r;
            if (out_valid) begin
                if (r) begin
                    $display("[TB] vec %0d word %0d data %04h last %0b", v, idx, out_data, out_last);
                    check("data", 32'(out_data), 32'(t.dout[idx]));
                    check("last", 32'(out_last), (idx == t.n_out - 1) ? 32'd1 : 32'd0);
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end else if (!t.toggle) begin
                check("no_bubble", 32'(out_valid), 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("all_words", 32'(idx), 32'(t.n_out));
        out_ready = 1'b0;
        check("after_valid", 32'(out_valid), 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd1);
        check("burst_len", 32'(burst_len), 32'(t.exp_len));
        check("overflow", 32'(overflow), 32'(t.exp_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < NVEC; v++) vecs[v] = '0;
        // 0: five-word ramp, ready held high
        vecs[0].n_in = 5; vecs[0].n_out = 5; vecs[0].exp_len = 5;
        for (int i = 0; i < 5; i++) begin
            vecs[0].din[i]  = DW'(16'h0001 + i);
            vecs[0].dout[i] = DW'(16'h0001 + i);
        end
        // 1: single word
        vecs[1].n_in = 1; vecs[1].n_out = 1; vecs[1].exp_len = 1;
        vecs[1].din[0] = 16'hBEEF; vecs[1].dout[0] = 16'hBEEF;
        // 2: exactly DEPTH words, ready toggling
        vecs[2].n_in = 8; vecs[2].n_out = 8; vecs[2].exp_len = 8; vecs[2].toggle = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vecs[2].din[i]  = DW'(16'h0010 + i);
            vecs[2].dout[i] = DW'(16'h0010 + i);
        end
        // 3: overflow, only the first DEPTH words survive
        vecs[3].n_in = 11; vecs[3].n_out = 8; vecs[3].exp_len = 8; vecs[3].exp_ovf = 1'b1;
        for (int i = 0; i < 11; i++) vecs[3].din[i] = DW'(16'h0020 + i);
        for (int i = 0; i < 8; i++) vecs[3].dout[i] = DW'(16'h0020 + i);
        // 4: reverse request
        vecs[4].n_in = 3; vecs[4].n_out = 3; vecs[4].exp_len = 3; vecs[4].rev = 1'b1;
        vecs[4].din[0] = 16'h000A; vecs[4].din[1] = 16'h000B; vecs[4].din[2] = 16'h000C;
`ifdef BURST_REPLAY_REVERSE_EN
        vecs[4].dout[0] = 16'h000C; vecs[4].dout[1] = 16'h000B; vecs[4].dout[2] = 16'h000A;
`else
        vecs[4].dout[0] = 16'h000A; vecs[4].dout[1] = 16'h000B; vecs[4].dout[2] = 16'h000C;
`endif
        // 5: overflow flag must clear on the next burst
        vecs[5].n_in = 2; vecs[5].n_out = 2; vecs[5].exp_len = 2;
        vecs[5].din[0] = 16'h0030; vecs[5].din[1] = 16'h0031;
        vecs[5].dout[0] = 16'h0030; vecs[5].dout[1] = 16'h0031;
        // 6: fresh burst after a mid-replay reset, toggled ready
        vecs[6].n_in = 3; vecs[6].n_out = 3; vecs[6].exp_len = 3; vecs[6].toggle = 1'b1;
        vecs[6].din[0] = 16'h0050; vecs[6].din[1] = 16'h0051; vecs[6].din[2] = 16'h0052;
        vecs[6].dout[0] = 16'h0050; vecs[6].dout[1] = 16'h0051; vecs[6].dout[2] = 16'h0052;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode_rev  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_burst_len", 32'(burst_len), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) run_vec(v);

        // Reset while replay is stalled with data in the skid FIFO
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h0040 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_drain_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("[TB] reset pulsed mid-drain");
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_burst_len", 32'(burst_len), 32'd0);

        run_vec(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
